// File: rtl/dist_filter_bcd_pkg.sv
// Shared constants, BCD FSM states and packed-BCD type for the distance filter.
package dist_pkg;

    localparam int BIN_W      = 14;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int MAX_CM_DEF = 400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } bcd_state_e;

    typedef logic [BCD_W-1:0] bcd_t;

    // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift.
    function automatic bcd_t bcd_adjust(input bcd_t v);
        bcd_t r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dist_filter_bcd_bin2bcd_seq.sv
// Sequential double-dabble converter: start/busy/done handshake, one bit per cycle.
module bin2bcd_seq
    import dist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output bcd_t             bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    bcd_state_e       state_r, state_s;
    logic [BIN_W-1:0] bin_r, bin_s;
    bcd_t             acc_r, acc_s, adj_s;
    logic [CNT_W-1:0] cnt_r;
    logic             last_s;

    // Next state and the shift datapath for the current bit.
    always_comb begin
        state_s = state_r;
        adj_s   = bcd_adjust(acc_r);
        acc_s   = {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
        bin_s   = {bin_r[BIN_W-2:0], 1'b0};
        last_s  = (state_r == SHIFT) && (cnt_r == CNT_W'(1));
        case (state_r)
            IDLE: begin
                if (start) state_s = LOAD;
                else       state_s = IDLE;
            end
            LOAD:  state_s = SHIFT;
            SHIFT: begin
                if (last_s) state_s = DONE;
                else        state_s = SHIFT;
            end
            DONE: begin
                if (start) state_s = LOAD;
                else       state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, shift registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            bin_r   <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
            done    <= last_s;
            if (last_s) bcd <= acc_s;
            case (state_r)
                LOAD: begin
                    bin_r <= bin;
                    acc_r <= '0;
                    cnt_r <= CNT_W'(BIN_W);
                end
                SHIFT: begin
                    bin_r <= bin_s;
                    acc_r <= acc_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/dist_filter_bcd.sv
// Distance clamp, moving average (built only with DIST_AVG_EN) and BCD conversion
// with a pending flag so that samples arriving mid-conversion trigger one re-conversion.
module dist_filter_bcd
    import dist_pkg::*;
#(
    parameter int DIST_W   = 24,
    parameter int AVG_LOG2 = 2,
    parameter int MAX_CM   = MAX_CM_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIST_W-1:0] i_distance,
    input  logic              i_dist_valid,
    output logic [BCD_W-1:0]  o_bcd,
    output logic              o_valid,
    output logic              o_over,
    output logic              o_busy
);

    logic             over_s;
    logic [BIN_W-1:0] clamp_s;
    logic [BIN_W-1:0] avg_s;
    logic             pending_r;
    logic             start_s;
    logic             over_r;
    bcd_t             bcd_s;

    assign over_s  = (i_distance > DIST_W'(MAX_CM));
    assign clamp_s = over_s ? BIN_W'(MAX_CM) : i_distance[BIN_W-1:0];

`ifdef DIST_AVG_EN
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = BIN_W + AVG_LOG2;

    logic [BIN_W-1:0]    win_r [DEPTH];
    logic [AVG_LOG2-1:0] wptr_r;
    logic [SUM_W-1:0]    sum_r;
    logic                first_r;

    // The first sample after reset fills the whole window so the average starts flat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) win_r[i] <= '0;
            wptr_r  <= '0;
            sum_r   <= '0;
            first_r <= 1'b1;
        end else if (i_dist_valid) begin
            if (first_r) begin
                for (int i = 0; i < DEPTH; i++) win_r[i] <= clamp_s;
                sum_r   <= SUM_W'(clamp_s) << AVG_LOG2;
                first_r <= 1'b0;
            end else begin
                sum_r         <= sum_r - SUM_W'(win_r[wptr_r]) + SUM_W'(clamp_s);
                win_r[wptr_r] <= clamp_s;
                wptr_r        <= wptr_r + AVG_LOG2'(1);
            end
        end else begin
            first_r <= first_r;
        end
    end

    assign avg_s = BIN_W'(sum_r >> AVG_LOG2);
`else
    logic [BIN_W-1:0] avg_r;

    // One register stage keeps the latency equal to the averaging build.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avg_r <= '0;
        end else if (i_dist_valid) begin
            avg_r <= clamp_s;
        end else begin
            avg_r <= avg_r;
        end
    end

    assign avg_s = avg_r;
`endif

    // The converter only takes a start while idle or on its DONE cycle.
    always_comb begin
        if (pending_r && (!o_busy || o_valid)) start_s = 1'b1;
        else                                   start_s = 1'b0;
    end

    // A strobe that coincides with an accepted start is covered by that LOAD's avg.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= 1'b0;
            over_r    <= 1'b0;
        end else begin
            if (start_s)           pending_r <= 1'b0;
            else if (i_dist_valid) pending_r <= 1'b1;
            else                   pending_r <= pending_r;
            if (i_dist_valid) over_r <= over_s;
            else              over_r <= over_r;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .bin   (avg_s),
        .busy  (o_busy),
        .done  (o_valid),
        .bcd   (bcd_s)
    );

    assign o_bcd  = bcd_s;
    assign o_over = over_r;

endmodule

// File: tb/tb_dist_filter_bcd.sv
// Self-checking bench for dist_filter_bcd; follows DIST_AVG_EN the same way as the design.
module tb_dist_filter_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] i_distance = 24'd0;
    logic        i_dist_valid = 1'b0;
    logic [15:0] o_bcd;
    logic        o_valid, o_over, o_busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int hist_cyc[$];
    int hist_avg[$];
    int win[$];
    int vcyc[$];
    int valid_cnt = 0;
    int last_valid_cyc = 0;
    logic [15:0] last_bcd = 16'h0000;

    dist_filter_bcd dut (
        .clk          (clk),
        .rst          (rst),
        .i_distance   (i_distance),
        .i_dist_valid (i_dist_valid),
        .o_bcd        (o_bcd),
        .o_valid      (o_valid),
        .o_over       (o_over),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clampv(input int d);
        return (d > 400) ? 400 : d;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference average after a sample: last four clamped samples, flat-filled on first.
    task automatic model_sample(input int d);
        int s;
        int avg;
        s = clampv(d);
`ifdef DIST_AVG_EN
        if (win.size() == 0) begin
            win = '{s, s, s, s};
        end else begin
            void'(win.pop_front());
            win.push_back(s);
        end
        avg = (win[0] + win[1] + win[2] + win[3]) / 4;
`else
        avg = s;
`endif
        hist_cyc.push_back(cyc);
        hist_avg.push_back(avg);
    endtask

    // Each o_valid must carry the average known when its LOAD happened (16 cycles earlier).
    always @(negedge clk) begin
        if (rst && o_valid) begin
            int idx;
            idx = -1;
            foreach (hist_cyc[i]) begin
                if (hist_cyc[i] <= cyc - 16) idx = i;
            end
            if (idx < 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                check("model_bcd", int'(o_bcd), int'(to_bcd(hist_avg[idx])));
            end
            valid_cnt++;
            last_valid_cyc = cyc;
            last_bcd = o_bcd;
            vcyc.push_back(cyc);
        end
    end

    task automatic strobe(input int d, output int scyc);
        @(posedge clk);
        #1;
        i_distance = 24'(d);
        i_dist_valid = 1'b1;
        scyc = cyc;
        model_sample(d);
        @(posedge clk);
        #1;
        i_dist_valid = 1'b0;
    endtask

    task automatic clear_model();
        hist_cyc.delete();
        hist_avg.delete();
        win.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_bcd", int'(o_bcd), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_over", int'(o_over), 0);
        check("rst_busy", int'(o_busy), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_valid(input string name, input int scyc);
        int v0;
        int n;
        v0 = valid_cnt;
        n = 0;
        while (valid_cnt == v0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (valid_cnt == v0) check({name, "_timeout"}, 0, 1);
        else                 check({name, "_latency"}, last_valid_cyc - scyc, 17);
    endtask

    initial begin
        int c;
        int c0;
        int v0;
        int dists[4];
        logic [15:0] exp4[4];

        dists = '{100, 200, 300, 400};
`ifdef DIST_AVG_EN
        exp4 = '{16'h0100, 16'h0125, 16'h0175, 16'h0250};
`else
        exp4 = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
`endif

        // Single sample: latency and exact value.
        do_reset();
        strobe(123, c);
        check("s1_over", int'(o_over), 0);
        wait_valid("s1", c);
        check("s1_bcd", int'(last_bcd), int'(16'h0123));
        repeat (5) @(posedge clk);
        #1;
        check("s1_hold", int'(o_bcd), int'(16'h0123));
        check("s1_idle_busy", int'(o_busy), 0);

        // Four spaced samples through the averaging window.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            strobe(dists[i], c);
            check("s2_over", int'(o_over), 0);
            wait_valid("s2", c);
            check("s2_bcd", int'(last_bcd), int'(exp4[i]));
            repeat (12) @(posedge clk);
        end

        // Saturation and the MAX_CM boundary.
        do_reset();
        strobe(1000, c);
        check("s3_over_hi", int'(o_over), 1);
        wait_valid("s3a", c);
        check("s3_bcd_sat", int'(last_bcd), int'(16'h0400));
        strobe(50, c);
        check("s3_over_lo", int'(o_over), 0);
        wait_valid("s3b", c);
`ifdef DIST_AVG_EN
        check("s3_bcd_50", int'(last_bcd), int'(16'h0312));
`else
        check("s3_bcd_50", int'(last_bcd), int'(16'h0050));
`endif
        strobe(401, c);
        check("s3_over_401", int'(o_over), 1);
        wait_valid("s3c", c);

        // Samples during a conversion collapse into one re-conversion.
        do_reset();
        v0 = valid_cnt;
        strobe(100, c0);
        repeat (3) @(posedge clk);
        strobe(200, c);
        repeat (3) @(posedge clk);
        strobe(300, c);
        while (cyc < c0 + 45) @(posedge clk);
        #1;
        check("s4_pulses", valid_cnt - v0, 2);
        if (valid_cnt - v0 >= 1) check("s4_first_cyc", vcyc[v0] - c0, 17);
        else                     check("s4_first_missing", 0, 1);
        check("s4_second_cyc", last_valid_cyc - c0, 33);
`ifdef DIST_AVG_EN
        check("s4_bcd", int'(last_bcd), int'(16'h0175));
`else
        check("s4_bcd", int'(last_bcd), int'(16'h0300));
`endif

        // Reset in the middle of a conversion.
        do_reset();
        v0 = valid_cnt;
        strobe(500, c);
        repeat (7) @(posedge clk);
        #1;
        check("s5_busy_before", int'(o_busy), 1);
        rst = 1'b0;
        clear_model();
        #2;
        check("s5_abort_busy", int'(o_busy), 0);
        check("s5_abort_bcd", int'(o_bcd), 0);
        check("s5_abort_over", int'(o_over), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("s5_no_valid", valid_cnt - v0, 0);
        strobe(77, c);
        wait_valid("s5", c);
        check("s5_bcd", int'(last_bcd), int'(16'h0077));

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=<20000 cycles", cyc);
        $fatal(1, "timeout");
    end

endmodule
